// File: rtl/pipe_req_arbiter_pkg.sv
// Shared types and helpers for the pipelined request arbiter.
// The round-robin pick lives here so the arbiter and any model agree on one definition.
package pipe_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 6;
    localparam int RW_DEF   = 13;
    localparam int LAT_DEF  = 3;

    // Sized for the largest supported requester count, so one tag type serves every NREQ.
    localparam int MAX_REQ  = 8;
    localparam int TAG_IW   = 3;

    typedef struct packed {
        logic              v;
        logic [TAG_IW-1:0] idx;
    } tag_t;

    // One-hot grant: first set bit of valid, scanning from ptr and wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [TAG_IW-1:0]  ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] g;
        logic               found;
        int                 j;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (!found && valid[j[TAG_IW-1:0]]) begin
                    g[j[TAG_IW-1:0]] = 1'b1;
                    found            = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/pipe_req_arbiter_if.sv
// Requester/pipeline/response bundle of the arbiter.
// The master side is the environment (requesters, pipeline, response consumers).
interface pipe_req_arbiter_if
    import pipe_arb_pkg::*;
#(
    parameter int  NREQ = NREQ_DEF,
    parameter int  DW   = DW_DEF,
    parameter int  RW   = RW_DEF,
    localparam int IW   = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ*DW-1:0] req_c;
    logic [NREQ*DW-1:0] req_d;
    logic [DW-1:0]      pipe_a;
    logic [DW-1:0]      pipe_b;
    logic [DW-1:0]      pipe_c;
    logic [DW-1:0]      pipe_d;
    logic [RW-1:0]      pipe_result;
    logic [NREQ-1:0]    rsp_valid;
    logic [RW-1:0]      rsp_data;
    logic [IW+1:0]      inflight;
    logic [15:0]        issue_cnt;

    modport master (
        output req_valid, req_a, req_b, req_c, req_d, pipe_result,
        input  req_ready, pipe_a, pipe_b, pipe_c, pipe_d, rsp_valid, rsp_data, inflight, issue_cnt
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_d, pipe_result,
        output req_ready, pipe_a, pipe_b, pipe_c, pipe_d, rsp_valid, rsp_data, inflight, issue_cnt
    );

endinterface

// File: rtl/pipe_req_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: request vector + start pointer in,
// one-hot grant and binary winner index out.
module rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int  N  = NREQ_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [MAX_REQ-1:0] g_full;

    always_comb begin
        g_full = rr_pick(MAX_REQ'(valid), TAG_IW'(ptr), N);
        grant  = g_full[N-1:0];
        idx    = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (g_full[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/pipe_req_arbiter.sv
// Shares one fixed-latency, stall-free arithmetic pipeline between NREQ requesters;
// a tag shift register running alongside the pipeline routes each result home.
module pipe_req_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int  NREQ = NREQ_DEF,
    parameter int  DW   = DW_DEF,
    parameter int  RW   = RW_DEF,
    parameter int  LAT  = LAT_DEF,
    localparam int IW   = $clog2(NREQ),
    localparam int CW   = IW + 2
) (
    input logic              clk,
    input logic              rst_n,
    pipe_req_arbiter_if.slave bus
);
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   widx;
    logic [IW-1:0]   ptr_nxt;
    logic [NREQ-1:0] grant;
    logic            xfer;
    logic            rsp_fire;
    tag_t            tag_pipe [LAT:0];

    rr_arbiter #(.N(NREQ)) u_arb (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (widx)
    );

    assign bus.req_ready = rst_n ? grant : '0;
    assign xfer          = |(bus.req_valid & bus.req_ready);
    assign ptr_nxt       = (widx == IW'(NREQ - 1)) ? '0 : widx + IW'(1);
    assign rsp_fire      = tag_pipe[LAT].v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr           <= '0;
            bus.pipe_a    <= '0;
            bus.pipe_b    <= '0;
            bus.pipe_c    <= '0;
            bus.pipe_d    <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.inflight  <= '0;
            bus.issue_cnt <= '0;
            for (int k = 0; k <= LAT; k++) tag_pipe[k] <= '0;
        end else begin
            if (xfer) ptr <= ptr_nxt;

            // Idle cycles feed zeros so the pipeline sees clean bubbles.
            bus.pipe_a    <= xfer ? bus.req_a[widx*DW +: DW] : '0;
            bus.pipe_b    <= xfer ? bus.req_b[widx*DW +: DW] : '0;
            bus.pipe_c    <= xfer ? bus.req_c[widx*DW +: DW] : '0;
            bus.pipe_d    <= xfer ? bus.req_d[widx*DW +: DW] : '0;
            bus.issue_cnt <= bus.issue_cnt + 16'(xfer);

            tag_pipe[0] <= '{v: xfer, idx: TAG_IW'(widx)};
            for (int k = 1; k <= LAT; k++) tag_pipe[k] <= tag_pipe[k-1];

            // Last tag lines up with pipe_result of the same operand set.
            if (rsp_fire) begin
                bus.rsp_valid <= NREQ'(1) << tag_pipe[LAT].idx;
                bus.rsp_data  <= bus.pipe_result;
            end else begin
                bus.rsp_valid <= '0;
            end

            case ({xfer, rsp_fire})
                2'b10:   bus.inflight <= bus.inflight + CW'(1);
                2'b01:   bus.inflight <= bus.inflight - CW'(1);
                default: bus.inflight <= bus.inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_req_arbiter.sv
// Directed bench for pipe_req_arbiter against a LAT=3 pipeline stub computing (A+B)*(C-D).
module tb_pipe_req_arbiter;
    import pipe_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 6;
    localparam int RW   = 13;
    localparam int LAT  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pipe_req_arbiter_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) bus ();

    pipe_req_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Pipeline stub: three register stages, result of operands sampled three edges earlier.
    logic [RW-1:0] s1, s2, s3;
    always_ff @(posedge clk) begin
        s1 <= (RW'(bus.pipe_a) + RW'(bus.pipe_b)) * (RW'(bus.pipe_c) - RW'(bus.pipe_d));
        s2 <= s1;
        s3 <= s2;
    end
    assign bus.pipe_result = s3;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, b, c, d);
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
        bus.req_c[i*DW +: DW] = c;
        bus.req_d[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_d = '0;
        bus.req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (bus.req_ready !== 4'b0000) $display("FAIL rst_ready: got %b exp 0000", bus.req_ready); else n_pass++;
        n_chk++; if ({bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d} !== '0) $display("FAIL rst_pipe: got %h exp 0", {bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d}); else n_pass++;
        n_chk++; if (bus.rsp_valid !== 4'b0000) $display("FAIL rst_rsp_valid: got %b exp 0000", bus.rsp_valid); else n_pass++;
        n_chk++; if (bus.rsp_data !== 13'd0) $display("FAIL rst_rsp_data: got %0d exp 0", bus.rsp_data); else n_pass++;
        n_chk++; if (bus.inflight !== 4'd0) $display("FAIL rst_inflight: got %0d exp 0", bus.inflight); else n_pass++;
        n_chk++; if (bus.issue_cnt !== 16'd0) $display("FAIL rst_issue_cnt: got %0d exp 0", bus.issue_cnt); else n_pass++;
        bus.req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int edges;
        logic seen;
        set_req(0, 21, 19, 20, 4);
        bus.req_valid = 4'b0001;
        #1;
        n_chk++; if (bus.req_ready !== 4'b0001) $display("FAIL single_grant: got %b exp 0001", bus.req_ready); else n_pass++;
        tick();
        bus.req_valid = '0;
        n_chk++; if ({bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d} !== {6'd21, 6'd19, 6'd20, 6'd4})
            $display("FAIL single_issue: got %0d,%0d,%0d,%0d exp 21,19,20,4", bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d); else n_pass++;
        n_chk++; if (bus.inflight !== 4'd1) $display("FAIL single_inflight1: got %0d exp 1", bus.inflight); else n_pass++;
        n_chk++; if (bus.issue_cnt !== 16'd1) $display("FAIL single_issue_cnt: got %0d exp 1", bus.issue_cnt); else n_pass++;
        edges = 1;
        seen  = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            edges++;
            if (bus.rsp_valid !== 4'b0000) seen = 1'b1;
        end
        n_chk++; if (!seen || edges != 5) $display("FAIL single_latency: got %0d edges (seen=%0b) exp 5", edges, seen); else n_pass++;
        n_chk++; if (bus.rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid: got %b exp 0001", bus.rsp_valid); else n_pass++;
        n_chk++; if (bus.rsp_data !== 13'd640) $display("FAIL single_rsp_data: got %0d exp 640", bus.rsp_data); else n_pass++;
        n_chk++; if (bus.inflight !== 4'd0) $display("FAIL single_inflight0: got %0d exp 0", bus.inflight); else n_pass++;
        tick();
        n_chk++; if (bus.rsp_valid !== 4'b0000) $display("FAIL single_strobe_len: got %b exp 0000", bus.rsp_valid); else n_pass++;
        n_chk++; if (bus.rsp_data !== 13'd640) $display("FAIL single_data_hold: got %0d exp 640", bus.rsp_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic seen;
        do_reset();
        set_req(1, 1, 9, 2, 2);
        bus.req_valid = 4'b0010;
        tick();
        set_req(1, 2, 4, 5, 2);
        #1;
        n_chk++; if (bus.req_ready !== 4'b0010) $display("FAIL b2b_grant2: got %b exp 0010", bus.req_ready); else n_pass++;
        tick();
        bus.req_valid = '0;
        n_chk++; if (bus.issue_cnt !== 16'd2) $display("FAIL b2b_issue_cnt: got %0d exp 2", bus.issue_cnt); else n_pass++;
        n_chk++; if (bus.inflight !== 4'd2) $display("FAIL b2b_inflight: got %0d exp 2", bus.inflight); else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (bus.rsp_valid !== 4'b0000) seen = 1'b1;
        end
        n_chk++; if (!seen || bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 13'd0)
            $display("FAIL b2b_rsp0: got valid=%b data=%0d exp 0010/0", bus.rsp_valid, bus.rsp_data); else n_pass++;
        tick();
        n_chk++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 13'd18)
            $display("FAIL b2b_rsp1: got valid=%b data=%0d exp 0010/18", bus.rsp_valid, bus.rsp_data); else n_pass++;
        tick();
        n_chk++; if (bus.rsp_valid !== 4'b0000 || bus.inflight !== 4'd0)
            $display("FAIL b2b_drain: got valid=%b inflight=%0d exp 0000/0", bus.rsp_valid, bus.inflight); else n_pass++;
    endtask

    task automatic test_all_four();
        int ri;
        logic [3:0] exp_v;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 6'(i + 1), 6'd0, 6'd1, 6'd0);
        ri = 0;
        for (int c = 0; c < 20; c++) begin
            n_chk++; if (!$onehot0(bus.rsp_valid)) $display("FAIL rr_onehot: got %b exp at most one bit", bus.rsp_valid); else n_pass++;
            if (bus.rsp_valid !== 4'b0000) begin
                exp_v = 4'b0001 << (ri % 4);
                n_chk++; if (bus.rsp_valid !== exp_v) $display("FAIL rr_rsp_idx: got %b exp %b", bus.rsp_valid, exp_v); else n_pass++;
                n_chk++; if (bus.rsp_data !== RW'(ri % 4 + 1)) $display("FAIL rr_rsp_data: got %0d exp %0d", bus.rsp_data, ri % 4 + 1); else n_pass++;
                ri++;
            end
            bus.req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                exp_v = 4'b0001 << (c % 4);
                n_chk++; if (bus.req_ready !== exp_v) $display("FAIL rr_grant: cycle %0d got %b exp %b", c, bus.req_ready, exp_v); else n_pass++;
            end
            tick();
        end
        n_chk++; if (ri != 8) $display("FAIL rr_rsp_count: got %0d exp 8", ri); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(2, 1, 1, 1, 0);
        bus.req_valid = 4'b0100;
        tick();
        set_req(3, 2, 2, 1, 0);
        set_req(0, 3, 3, 1, 0);
        bus.req_valid = 4'b1001;
        #1;
        n_chk++; if (bus.req_ready !== 4'b1000) $display("FAIL wrap_first: got %b exp 1000", bus.req_ready); else n_pass++;
        tick();
        n_chk++; if (bus.req_ready !== 4'b0001) $display("FAIL wrap_second: got %b exp 0001", bus.req_ready); else n_pass++;
        tick();
        n_chk++; if (bus.req_ready !== 4'b1000) $display("FAIL wrap_third: got %b exp 1000", bus.req_ready); else n_pass++;
        bus.req_valid = '0;
        repeat (8) tick();
        n_chk++; if (bus.inflight !== 4'd0) $display("FAIL wrap_inflight: got %0d exp 0", bus.inflight); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int stale;
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 6'(i + 1), 6'd1, 6'd3, 6'd1);
        bus.req_valid = 4'b0111;
        repeat (3) tick();
        bus.req_valid = '0;
        n_chk++; if (bus.inflight !== 4'd3) $display("FAIL mid_inflight3: got %0d exp 3", bus.inflight); else n_pass++;
        rst_n = 1'b0;
        bus.req_valid = 4'hF;
        #1;
        n_chk++; if (bus.req_ready !== 4'b0000) $display("FAIL mid_ready_in_rst: got %b exp 0000", bus.req_ready); else n_pass++;
        tick();
        n_chk++; if (bus.inflight !== 4'd0) $display("FAIL mid_inflight0: got %0d exp 0", bus.inflight); else n_pass++;
        n_chk++; if ({bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d} !== '0) $display("FAIL mid_pipe: got %h exp 0", {bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d}); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_chk++; if (bus.req_ready !== 4'b0001) $display("FAIL mid_next_grant: got %b exp 0001", bus.req_ready); else n_pass++;
        bus.req_valid = '0;
        stale = 0;
        repeat (8) begin
            tick();
            if (bus.rsp_valid !== 4'b0000) stale++;
        end
        n_chk++; if (stale != 0) $display("FAIL mid_stale_rsp: got %0d responses exp 0", stale); else n_pass++;
    endtask

    task automatic test_sparse();
        int nrsp;
        nrsp = 0;
        for (int c = 0; c < 28; c++) begin
            if (bus.rsp_valid !== 4'b0000) begin
                nrsp++;
                n_chk++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 13'd153)
                    $display("FAIL sparse_rsp: got valid=%b data=%0d exp 0100/153", bus.rsp_valid, bus.rsp_data); else n_pass++;
            end
            if (c % 7 == 2) begin
                n_chk++; if ({bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d} !== '0)
                    $display("FAIL sparse_bubble: got %h exp 0", {bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_d}); else n_pass++;
            end
            if (c % 7 == 0 && c < 21) begin
                set_req(2, 8, 9, 10, 1);
                bus.req_valid = 4'b0100;
            end else begin
                bus.req_valid = '0;
            end
            tick();
        end
        n_chk++; if (nrsp != 3) $display("FAIL sparse_count: got %0d exp 3", nrsp); else n_pass++;
    endtask

    initial begin
        bus.req_valid = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_all_four();
        test_wrap();
        test_reset_midflight();
        test_sparse();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_req_arbiter.md
Name: pipe_req_arbiter

Overview:
Shares one free-running arithmetic pipeline (operands A,B,C,D, DW bits each; result RW bits; fixed latency LAT) between NREQ requesters.
- Arbitrates round-robin and registers the winning operand set onto the pipeline inputs.
- Tags every issue with the requester index and returns each result to its originator.
- Sits between the requesting engines and the existing pipeline, which has no valid, enable or stall of its own.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 6, operand width
RW, 13, pipeline result width
LAT, 3, pipeline latency in clk cycles, from operands sampled to Result valid
IW, $clog2(NREQ), requester index width (derived, not overridable)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester operand set valid
req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high
req_a, req_b, req_c, req_d  in  NREQ*DW each  packed operands; requester i occupies bits [i*DW +: DW]
pipe_a, pipe_b, pipe_c, pipe_d  out  DW each  registered operands to the pipeline
pipe_result  in  RW  pipeline Result
rsp_valid  out  NREQ  one-hot single-cycle response strobe
rsp_data  out  RW  result, valid only while some rsp_valid bit is high
inflight  out  IW+2  count of issued operand sets not yet returned
issue_cnt  out  16  total issues since reset; wraps at 65535 -> 0

Behaviour:
Reset:
- rst_n low at a clk edge clears pipe_a..d, rsp_valid, rsp_data, inflight, issue_cnt, the whole tag shift register and the RR pointer (ptr=0).
- req_ready is 0 while rst_n is low.
- Reset mid-operation: in-flight results are dropped and never signalled.

Arbitration (combinational):
- Search req_valid starting at index ptr, wrapping modulo NREQ; the first set bit wins.
- req_ready is one-hot on the winner, all-zero if no request. req_ready may depend on req_valid.
- Requesters must hold operands stable while valid and not granted.
- On a transfer, ptr <= winner+1 mod NREQ. With no transfer, ptr holds.
- At most one issue per cycle, so throughput is 1/cycle; no requester waits more than NREQ-1 grants.

Issue stage (registered):
- On a transfer, pipe_a..d <= winner's operands.
- With no transfer, pipe_a..d <= 0 (idle bubble).
- issue_cnt increments on each transfer.

Tag tracking:
- Shift register of LAT+1 entries {v, idx}. Entry 0 <= {transfer, winner}; entry k <= entry k-1.
- When the last entry has v=1:
  - rsp_valid[idx] = 1 and rsp_data = pipe_result, both registered on that edge.
  - Otherwise rsp_valid = 0 and rsp_data holds its last value.
- Handshake-to-response latency is exactly LAT+2 clk edges: the transfer edge, then LAT pipeline edges, then the response register edge.
- No response backpressure: consumers must accept rsp_valid when it fires.
- Bubble results (v=0) are never signalled.

inflight:
- +1 on a transfer, -1 on a response; both in one cycle means no change.
- Never exceeds LAT+2.

Decomposition:
- Shared package pipe_arb_pkg holds:
  - default DW, RW, LAT
  - typedef tag_t {logic v; logic [IW-1:0] idx}
  - function rr_pick(valid, ptr) returning the one-hot grant
- One sub-module is natural: rr_arbiter (valid vector + pointer in, one-hot grant and index out, purely combinational).
- The tag shift register and operand mux stay in the top module.

Test Plan:
Bench uses a pipeline stub with LAT=3 computing (A+B)*(C-D).
- Single request, req0 A=21 B=19 C=20 D=4 -> rsp_valid=4'b0001 exactly 5 edges after the handshake; rsp_data=640; inflight returns to 0.
- Back-to-back: req1 issues (1,9,2,2) then (2,4,5,2) on consecutive cycles -> rsp_valid[1] on two consecutive cycles with rsp_data 0 then 18; issue_cnt=2.
- All four valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each response returns to the originating index; no two rsp_valid bits high together.
- Pointer wrap: ptr=3 with req_valid=4'b1001 -> req3 is granted first, then req0.
- Reset mid-flight: assert rst_n=0 for one cycle with 3 issues outstanding -> no rsp_valid afterwards; inflight=0; pipe_a..d=0; next grant goes to req0.
- Sparse traffic: one request every 7 cycles on req2, values (8,9,10,1) -> rsp_data=153; the zero-result bubbles between requests never raise rsp_valid.
